mem_stage_lsu: RTL and testbench



---
 rtl/mem_stage_lsu_pkg.sv | 60 ++++++
 rtl/mem_stage_lsu_lane_align.sv | 55 +++++
 rtl/mem_stage_lsu.sv | 184 ++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: memory aluop codes,
// exception codes, FSM state encoding and the memory-op decoder.
package mem_stage_lsu_pkg;

  localparam int unsigned EXC_CODE_WIDTH = 5;

  // Memory aluop codes
  localparam logic [7:0] AluopLb  = 8'hE0;
  localparam logic [7:0] AluopLh  = 8'hE1;
  localparam logic [7:0] AluopLw  = 8'hE3;
  localparam logic [7:0] AluopLbu = 8'hE4;
  localparam logic [7:0] AluopLhu = 8'hE5;
  localparam logic [7:0] AluopSb  = 8'hE8;
  localparam logic [7:0] AluopSh  = 8'hE9;
  localparam logic [7:0] AluopSw  = 8'hEB;

  // Exception codes; EC_None is zero so that reset leaves every output at zero
  localparam logic [EXC_CODE_WIDTH-1:0] EC_None = 5'h00;
  localparam logic [EXC_CODE_WIDTH-1:0] EC_AdEL = 5'h04;
  localparam logic [EXC_CODE_WIDTH-1:0] EC_AdES = 5'h05;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWait  = 2'd1,
    StDone  = 2'd2,
    StDrain = 2'd3
  } lsu_state_e;

  typedef enum logic [1:0] {
    SizeByte = 2'd0,
    SizeHalf = 2'd1,
    SizeWord = 2'd2
  } mem_size_e;

  typedef struct packed {
    logic      is_mem;
    logic      is_load;
    logic      is_signed;
    mem_size_e size;
  } mem_op_t;

  // Decode an aluop into access kind, size and extension mode.
  function automatic mem_op_t decode_mem_op(input logic [7:0] aluop);
    mem_op_t op;
    op = '{is_mem: 1'b0, is_load: 1'b0, is_signed: 1'b0, size: SizeWord};
    case (aluop)
      AluopLb:  op = '{is_mem: 1'b1, is_load: 1'b1, is_signed: 1'b1, size: SizeByte};
      AluopLbu: op = '{is_mem: 1'b1, is_load: 1'b1, is_signed: 1'b0, size: SizeByte};
      AluopLh:  op = '{is_mem: 1'b1, is_load: 1'b1, is_signed: 1'b1, size: SizeHalf};
      AluopLhu: op = '{is_mem: 1'b1, is_load: 1'b1, is_signed: 1'b0, size: SizeHalf};
      AluopLw:  op = '{is_mem: 1'b1, is_load: 1'b1, is_signed: 1'b0, size: SizeWord};
      AluopSb:  op = '{is_mem: 1'b1, is_load: 1'b0, is_signed: 1'b0, size: SizeByte};
      AluopSh:  op = '{is_mem: 1'b1, is_load: 1'b0, is_signed: 1'b0, size: SizeHalf};
      AluopSw:  op = '{is_mem: 1'b1, is_load: 1'b0, is_signed: 1'b0, size: SizeWord};
      default:  ;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mem_stage_lsu_lane_align.sv
// Byte-lane steering: store byte enables / replicated write data, and
// load-data extraction with sign or zero extension.
module mem_stage_lsu_lane_align
  import mem_stage_lsu_pkg::*;
(
  input  mem_op_t     op_i,
  input  logic [1:0]  byte_sel_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] load_word_i,
  output logic [3:0]  be_o,
  output logic [31:0] store_wdata_o,
  output logic [31:0] load_data_o
);

  logic [7:0]  load_byte;
  logic [15:0] load_half;

  // Store lanes: narrow stores replicate data across lanes; loads read the whole word
  always_comb begin
    be_o          = 4'b1111;
    store_wdata_o = store_data_i;
    if (!op_i.is_load) begin
      case (op_i.size)
        SizeByte: begin
          be_o          = 4'b0001 << byte_sel_i;
          store_wdata_o = {4{store_data_i[7:0]}};
        end
        SizeHalf: begin
          be_o          = byte_sel_i[1] ? 4'b1100 : 4'b0011;
          store_wdata_o = {2{store_data_i[15:0]}};
        end
        default: ;
      endcase
    end
  end

  // Load extraction: pick the addressed byte/halfword and extend to 32 bits
  always_comb begin
    case (byte_sel_i)
      2'd0:    load_byte = load_word_i[7:0];
      2'd1:    load_byte = load_word_i[15:8];
      2'd2:    load_byte = load_word_i[23:16];
      default: load_byte = load_word_i[31:24];
    endcase
    load_half = byte_sel_i[1] ? load_word_i[31:16] : load_word_i[15:0];
    case (op_i.size)
      SizeByte: load_data_o = op_i.is_signed ? {{24{load_byte[7]}}, load_byte}
                                             : {24'h0, load_byte};
      SizeHalf: load_data_o = op_i.is_signed ? {{16{load_half[15]}}, load_half}
                                             : {16'h0, load_half};
      default:  load_data_o = load_word_i;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: alignment check, req/ack data bus sequencing,
// load data merge into writeback and address-error exception generation.
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int unsigned EXC_W = EXC_CODE_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [4:0]       mem_wd,
  input  logic             mem_wreg,
  input  logic [31:0]      mem_wdata,
  input  logic [7:0]       mem_aluop,
  input  logic [31:0]      mem_mem_addr,
  input  logic [31:0]      mem_reg2,
  input  logic [EXC_W-1:0] exc_code_i,
  input  logic [31:0]      exc_epc_i,
  input  logic [31:0]      exc_badvaddr_i,
  output logic             dbus_req,
  output logic             dbus_we,
  output logic [3:0]       dbus_be,
  output logic [31:0]      dbus_addr,
  output logic [31:0]      dbus_wdata,
  input  logic             dbus_ack,
  input  logic [31:0]      dbus_rdata,
  output logic [4:0]       wb_wd,
  output logic             wb_wreg,
  output logic [31:0]      wb_wdata,
  output logic             stallreq,
  output logic [EXC_W-1:0] exc_code_o,
  output logic [31:0]      exc_epc_o,
  output logic [31:0]      exc_badvaddr_o
);

  lsu_state_e  state_q;
  logic [31:0] rdata_q;
  // Bus fields latched at issue so WAIT/DRAIN hold them even if EX/MEM changes
  logic        bus_we_q;
  logic [3:0]  bus_be_q;
  logic [31:0] bus_addr_q;
  logic [31:0] bus_wdata_q;

  mem_op_t     op;
  logic        exc_in;
  logic        misaligned;
  logic        access_ok;
  logic        issue;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] load_data;
  logic [31:0] word_addr;

  assign op         = decode_mem_op(mem_aluop);
  assign exc_in     = (exc_code_i != EXC_W'(EC_None));
  assign misaligned = op.is_mem &&
                      (((op.size == SizeHalf) && mem_mem_addr[0]) ||
                       ((op.size == SizeWord) && (mem_mem_addr[1:0] != 2'b00)));
  assign access_ok  = op.is_mem && !exc_in && !misaligned;
  assign issue      = (state_q == StIdle) && access_ok && !flush;
  assign word_addr  = {mem_mem_addr[31:2], 2'b00};

  mem_stage_lsu_lane_align u_lane_align (
    .op_i         (op),
    .byte_sel_i   (mem_mem_addr[1:0]),
    .store_data_i (mem_reg2),
    .load_word_i  (rdata_q),
    .be_o         (lane_be),
    .store_wdata_o(lane_wdata),
    .load_data_o  (load_data)
  );

  // Bus sequencing FSM with load-data capture and issue-time bus latch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      rdata_q     <= 32'h0;
      bus_we_q    <= 1'b0;
      bus_be_q    <= 4'h0;
      bus_addr_q  <= 32'h0;
      bus_wdata_q <= 32'h0;
    end else begin
      case (state_q)
        StIdle: begin
          if (issue) begin
            bus_we_q    <= !op.is_load;
            bus_be_q    <= lane_be;
            bus_addr_q  <= word_addr;
            bus_wdata_q <= lane_wdata;
            if (dbus_ack) begin
              rdata_q <= dbus_rdata;
              state_q <= StDone;
            end else begin
              state_q <= StWait;
            end
          end
        end
        StWait: begin
          if (dbus_ack) begin
            rdata_q <= dbus_rdata;
            // A flush arriving with the ack simply discards the result
            state_q <= flush ? StIdle : StDone;
          end else if (flush) begin
            state_q <= StDrain;
          end
        end
        StDone:  state_q <= StIdle;
        StDrain: if (dbus_ack) state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Output resolution: passthrough, exceptions, bus drive and writeback merge
  always_comb begin
    wb_wd          = mem_wd;
    wb_wreg        = mem_wreg;
    wb_wdata       = mem_wdata;
    exc_code_o     = exc_code_i;
    exc_epc_o      = exc_epc_i;
    exc_badvaddr_o = exc_badvaddr_i;
    dbus_req       = 1'b0;
    dbus_we        = 1'b0;
    dbus_be        = 4'h0;
    dbus_addr      = 32'h0;
    dbus_wdata     = 32'h0;
    stallreq       = 1'b0;

    if (op.is_mem) begin
      wb_wreg = 1'b0;
      if (!exc_in && misaligned) begin
        exc_code_o     = op.is_load ? EXC_W'(EC_AdEL) : EXC_W'(EC_AdES);
        exc_badvaddr_o = mem_mem_addr;
      end
    end

    case (state_q)
      StIdle: begin
        if (issue) begin
          dbus_req   = 1'b1;
          dbus_we    = !op.is_load;
          dbus_be    = lane_be;
          dbus_addr  = word_addr;
          dbus_wdata = lane_wdata;
          stallreq   = 1'b1;
        end
      end
      StWait, StDrain: begin
        dbus_req   = 1'b1;
        dbus_we    = bus_we_q;
        dbus_be    = bus_be_q;
        dbus_addr  = bus_addr_q;
        dbus_wdata = bus_wdata_q;
        stallreq   = 1'b1;
        wb_wreg    = 1'b0;
      end
      StDone: begin
        // Stores keep wb_wdata = mem_wdata with writeback suppressed
        if (op.is_load) begin
          wb_wdata = load_data;
          wb_wreg  = mem_wreg;
        end
      end
      default: ;
    endcase

    // Asynchronous reset forces every output to its idle value at once
    if (!rst) begin
      wb_wd          = 5'h0;
      wb_wreg        = 1'b0;
      wb_wdata       = 32'h0;
      exc_code_o     = EXC_W'(EC_None);
      exc_epc_o      = 32'h0;
      exc_badvaddr_o = 32'h0;
      dbus_req       = 1'b0;
      dbus_we        = 1'b0;
      dbus_be        = 4'h0;
      dbus_addr      = 32'h0;
      dbus_wdata     = 32'h0;
      stallreq       = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed self-checking bench for mem_stage_lsu.
module tb_mem_stage_lsu;
  import mem_stage_lsu_pkg::*;

  localparam logic [7:0] AluopOr = 8'h25;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic [7:0]  mem_aluop;
  logic [31:0] mem_mem_addr;
  logic [31:0] mem_reg2;
  logic [4:0]  exc_code_i;
  logic [31:0] exc_epc_i;
  logic [31:0] exc_badvaddr_i;
  logic        dbus_req;
  logic        dbus_we;
  logic [3:0]  dbus_be;
  logic [31:0] dbus_addr;
  logic [31:0] dbus_wdata;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic        stallreq;
  logic [4:0]  exc_code_o;
  logic [31:0] exc_epc_o;
  logic [31:0] exc_badvaddr_o;

  int n_checks = 0;
  int n_fail   = 0;

  mem_stage_lsu #(.EXC_W(5)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .mem_wd        (mem_wd),
    .mem_wreg      (mem_wreg),
    .mem_wdata     (mem_wdata),
    .mem_aluop     (mem_aluop),
    .mem_mem_addr  (mem_mem_addr),
    .mem_reg2      (mem_reg2),
    .exc_code_i    (exc_code_i),
    .exc_epc_i     (exc_epc_i),
    .exc_badvaddr_i(exc_badvaddr_i),
    .dbus_req      (dbus_req),
    .dbus_we       (dbus_we),
    .dbus_be       (dbus_be),
    .dbus_addr     (dbus_addr),
    .dbus_wdata    (dbus_wdata),
    .dbus_ack      (dbus_ack),
    .dbus_rdata    (dbus_rdata),
    .wb_wd         (wb_wd),
    .wb_wreg       (wb_wreg),
    .wb_wdata      (wb_wdata),
    .stallreq      (stallreq),
    .exc_code_o    (exc_code_o),
    .exc_epc_o     (exc_epc_o),
    .exc_badvaddr_o(exc_badvaddr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; callers sample 4 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One bus access with ack after ack_dly cycles; checks bus fields and DONE writeback.
  task automatic access(input string tag, input logic [7:0] op, input logic [31:0] addr,
                        input logic [31:0] reg2, input logic [31:0] rdata, input int ack_dly,
                        input logic exp_we, input logic [3:0] exp_be,
                        input logic [31:0] exp_bwdata, input logic [31:0] exp_wb,
                        input logic exp_wreg);
    int stalls;
    stalls       = 0;
    mem_aluop    = op;
    mem_mem_addr = addr;
    mem_reg2     = reg2;
    mem_wdata    = addr;
    mem_wreg     = 1'b1;
    mem_wd       = 5'd7;
    for (int i = 0; i <= ack_dly; i++) begin
      dbus_ack   = (i == ack_dly);
      dbus_rdata = (i == ack_dly) ? rdata : 32'h0;
      #4;
      if (stallreq) stalls++;
      check_eq({tag, ".req"}, 32'(dbus_req), 32'd1);
      if (i == 0) begin
        check_eq({tag, ".we"}, 32'(dbus_we), 32'(exp_we));
        check_eq({tag, ".be"}, 32'(dbus_be), 32'(exp_be));
        check_eq({tag, ".addr"}, dbus_addr, {addr[31:2], 2'b00});
        if (exp_we) check_eq({tag, ".bus_wdata"}, dbus_wdata, exp_bwdata);
      end
      step();
    end
    dbus_ack   = 1'b0;
    dbus_rdata = 32'h0;
    #4;
    check_eq({tag, ".done_stall"}, 32'(stallreq), 32'd0);
    check_eq({tag, ".done_req"}, 32'(dbus_req), 32'd0);
    check_eq({tag, ".wb_wdata"}, wb_wdata, exp_wb);
    check_eq({tag, ".wb_wreg"}, 32'(wb_wreg), 32'(exp_wreg));
    check_eq({tag, ".wb_wd"}, 32'(wb_wd), 32'd7);
    check_eq({tag, ".stall_cycles"}, 32'(stalls), 32'(ack_dly + 1));
    step();
    mem_aluop = AluopOr;
    mem_wreg  = 1'b0;
  endtask

  initial begin
    rst            = 1'b0;
    flush          = 1'b0;
    mem_wd         = 5'd3;
    mem_wreg       = 1'b1;
    mem_wdata      = 32'h0000_1234;
    mem_aluop      = AluopOr;
    mem_mem_addr   = 32'h0;
    mem_reg2       = 32'h0;
    exc_code_i     = EC_None;
    exc_epc_i      = 32'h0000_1111;
    exc_badvaddr_i = 32'h0;
    dbus_ack       = 1'b0;
    dbus_rdata     = 32'h0;

    // Reset state
    #4;
    check_eq("rst.wb_wdata", wb_wdata, 32'h0);
    check_eq("rst.wb_wreg", 32'(wb_wreg), 32'd0);
    check_eq("rst.req", 32'(dbus_req), 32'd0);
    check_eq("rst.stall", 32'(stallreq), 32'd0);
    check_eq("rst.epc", exc_epc_o, 32'h0);
    check_eq("rst.code", 32'(exc_code_o), 32'(EC_None));
    @(negedge clk);
    rst = 1'b1;
    step();

    // Non-memory op passes straight through
    #4;
    check_eq("pass.wb_wdata", wb_wdata, 32'h0000_1234);
    check_eq("pass.wb_wreg", 32'(wb_wreg), 32'd1);
    check_eq("pass.wb_wd", 32'(wb_wd), 32'd3);
    check_eq("pass.epc", exc_epc_o, 32'h0000_1111);
    check_eq("pass.req", 32'(dbus_req), 32'd0);
    check_eq("pass.stall", 32'(stallreq), 32'd0);
    step();

    access("lw",  AluopLw,  32'h100, 32'h0, 32'hDEADBEEF, 3, 1'b0, 4'b1111, 32'h0,
           32'hDEADBEEF, 1'b1);
    access("lb",  AluopLb,  32'h103, 32'h0, 32'h80112233, 1, 1'b0, 4'b1111, 32'h0,
           32'hFFFFFF80, 1'b1);
    access("lbu", AluopLbu, 32'h103, 32'h0, 32'h80112233, 1, 1'b0, 4'b1111, 32'h0,
           32'h00000080, 1'b1);
    access("lh",  AluopLh,  32'h102, 32'h0, 32'h80112233, 0, 1'b0, 4'b1111, 32'h0,
           32'hFFFF8011, 1'b1);
    access("lhu", AluopLhu, 32'h100, 32'h0, 32'h8011A233, 2, 1'b0, 4'b1111, 32'h0,
           32'h0000A233, 1'b1);
    access("sh",  AluopSh,  32'h202, 32'h0000ABCD, 32'h0, 0, 1'b1, 4'b1100, 32'hABCDABCD,
           32'h202, 1'b0);
    access("sb",  AluopSb,  32'h201, 32'h12345678, 32'h0, 2, 1'b1, 4'b0010, 32'h78787878,
           32'h201, 1'b0);
    access("sw",  AluopSw,  32'h300, 32'hCAFEF00D, 32'h0, 1, 1'b1, 4'b1111, 32'hCAFEF00D,
           32'h300, 1'b0);

    // Misaligned word load
    mem_aluop    = AluopLw;
    mem_mem_addr = 32'h102;
    mem_wreg     = 1'b1;
    exc_epc_i    = 32'hBFC0_0100;
    #4;
    check_eq("adel.code", 32'(exc_code_o), 32'(EC_AdEL));
    check_eq("adel.badvaddr", exc_badvaddr_o, 32'h102);
    check_eq("adel.epc", exc_epc_o, 32'hBFC0_0100);
    check_eq("adel.req", 32'(dbus_req), 32'd0);
    check_eq("adel.stall", 32'(stallreq), 32'd0);
    check_eq("adel.wb_wreg", 32'(wb_wreg), 32'd0);
    step();
    #4;
    check_eq("adel.req2", 32'(dbus_req), 32'd0);
    step();

    // Misaligned halfword store
    mem_aluop    = AluopSh;
    mem_mem_addr = 32'h201;
    #4;
    check_eq("ades.code", 32'(exc_code_o), 32'(EC_AdES));
    check_eq("ades.badvaddr", exc_badvaddr_o, 32'h201);
    check_eq("ades.req", 32'(dbus_req), 32'd0);
    step();

    // Incoming exception wins over misalignment and blocks the access
    mem_aluop      = AluopSw;
    mem_mem_addr   = 32'h301;
    exc_code_i     = 5'd12;
    exc_badvaddr_i = 32'h55;
    exc_epc_i      = 32'hBFC0_0200;
    #4;
    check_eq("excin.code", 32'(exc_code_o), 32'd12);
    check_eq("excin.badvaddr", exc_badvaddr_o, 32'h55);
    check_eq("excin.epc", exc_epc_o, 32'hBFC0_0200);
    check_eq("excin.req", 32'(dbus_req), 32'd0);
    check_eq("excin.stall", 32'(stallreq), 32'd0);
    check_eq("excin.wb_wreg", 32'(wb_wreg), 32'd0);
    step();
    exc_code_i     = EC_None;
    exc_badvaddr_i = 32'h0;
    mem_aluop      = AluopOr;
    mem_wreg       = 1'b0;

    // Flush while waiting: request held until ack, then result dropped
    mem_aluop    = AluopLw;
    mem_mem_addr = 32'h400;
    mem_wreg     = 1'b1;
    #4;
    check_eq("flush.issue_req", 32'(dbus_req), 32'd1);
    step();
    flush = 1'b1;
    #4;
    check_eq("flush.wait_req", 32'(dbus_req), 32'd1);
    check_eq("flush.wait_stall", 32'(stallreq), 32'd1);
    step();
    flush     = 1'b0;
    mem_aluop = AluopOr;
    mem_wreg  = 1'b0;
    mem_wdata = 32'h0;
    #4;
    check_eq("flush.drain_req", 32'(dbus_req), 32'd1);
    check_eq("flush.drain_addr", dbus_addr, 32'h400);
    check_eq("flush.drain_stall", 32'(stallreq), 32'd1);
    check_eq("flush.drain_wreg", 32'(wb_wreg), 32'd0);
    step();
    dbus_ack   = 1'b1;
    dbus_rdata = 32'h9999_9999;
    #4;
    check_eq("flush.ack_req", 32'(dbus_req), 32'd1);
    step();
    dbus_ack   = 1'b0;
    dbus_rdata = 32'h0;
    #4;
    check_eq("flush.idle_req", 32'(dbus_req), 32'd0);
    check_eq("flush.idle_stall", 32'(stallreq), 32'd0);
    check_eq("flush.idle_wdata", wb_wdata, 32'h0);
    step();

    // Reset while waiting forces all outputs to zero immediately
    mem_aluop    = AluopLw;
    mem_mem_addr = 32'h500;
    mem_wdata    = 32'h500;
    mem_wreg     = 1'b1;
    #4;
    check_eq("rstw.issue_req", 32'(dbus_req), 32'd1);
    step();
    #2;
    check_eq("rstw.wait_req", 32'(dbus_req), 32'd1);
    rst = 1'b0;
    #1;
    check_eq("rstw.req", 32'(dbus_req), 32'd0);
    check_eq("rstw.stall", 32'(stallreq), 32'd0);
    check_eq("rstw.addr", dbus_addr, 32'h0);
    check_eq("rstw.wb_wdata", wb_wdata, 32'h0);
    check_eq("rstw.epc", exc_epc_o, 32'h0);
    mem_aluop = AluopOr;
    mem_wreg  = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step();
    #4;
    check_eq("rstw.after_req", 32'(dbus_req), 32'd0);
    check_eq("rstw.after_stall", 32'(stallreq), 32'd0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
